// File: rtl/operand_stream_tx_pkg.sv
// Shared types and helpers for the operand stream transmitter.
// Holds the FSM encoding, buffer depth and width helpers.
package operand_stream_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int FIFO_DEPTH = 2;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO used as the output skid buffer of an operand stream.
// The head entry is a register, so dout never depends on pop.
module stream_skid_fifo
    import operand_stream_tx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               pop,
    output logic [WIDTH-1:0]                   dout,
    output logic [occ_width(FIFO_DEPTH)-1:0]   occ
);

    localparam int OW = occ_width(FIFO_DEPTH);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) head <= din;
                    else           tail <= din;
                    occ <= occ + OW'(1);
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - OW'(1);
                end
                2'b11: begin
                    // simultaneous write and pop keeps occupancy constant
                    if (occ == OW'(1)) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = head;

endmodule

// File: rtl/operand_stream_tx.sv
// Operand stream transmitter: reads a word list from a 1-cycle memory
// and presents it on a valid/ready port through a 2-entry skid buffer.
module operand_stream_tx
    import operand_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_HEIGHT = 1 << 16,
    parameter int LEN_WIDTH  = 20
) (
    input  logic                                clk,
    input  logic                                arst_n_in,
    input  logic                                start,
    input  logic [addr_width(MEM_HEIGHT)-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]                length,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_re,
    output logic [addr_width(MEM_HEIGHT)-1:0]   mem_read_addr,
    input  logic [DATA_WIDTH-1:0]               mem_qout,
    output logic [DATA_WIDTH-1:0]               tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready
);

    localparam int AW = addr_width(MEM_HEIGHT);
    localparam int OW = occ_width(FIFO_DEPTH);

    state_t               state;
    state_t               state_nxt;
    logic [AW-1:0]        base_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] issued_cnt;
    logic [LEN_WIDTH-1:0] sent_cnt;
    logic                 inflight;
    logic                 pop;
    logic                 room;
    logic [OW-1:0]        occ;
    logic [OW:0]          pending;
    logic                 accept;

    assign pop    = tx_valid & tx_ready;
    assign accept = (state == IDLE) & start;

    // words already owed to the buffer once this cycle's pop retires
    assign pending = {1'b0, occ}
                   + (OW + 1)'(inflight)
                   - (OW + 1)'(pop);
    assign room    = pending < (OW + 1)'(FIFO_DEPTH);

    assign mem_re        = (state == RUN) & (issued_cnt < len_q) & room;
    assign mem_read_addr = base_q + issued_cnt[AW-1:0];

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign tx_valid = (occ != '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (length == '0) ? DONE : RUN;
            end
            RUN: begin
                if (pop && (sent_cnt + LEN_WIDTH'(1) == len_q))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_cnt <= '0;
            sent_cnt   <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= mem_re;
            if (accept) begin
                base_q     <= base_addr;
                len_q      <= length;
                issued_cnt <= '0;
                sent_cnt   <= '0;
            end else begin
                if (mem_re) issued_cnt <= issued_cnt + LEN_WIDTH'(1);
                if (pop)    sent_cnt   <= sent_cnt + LEN_WIDTH'(1);
            end
        end
    end

    stream_skid_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (arst_n_in),
        .push  (inflight),
        .din   (mem_qout),
        .pop   (pop),
        .dout  (tx_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_operand_stream_tx.sv
// Bench for operand_stream_tx: queue-based stream model plus directed
// scenarios with hand-computed cycle traces.
module tb_operand_stream_tx;

    logic        clk;
    logic        arst_n_in;
    logic        start;
    logic        start16;
    logic [15:0] base;
    logic [19:0] len;
    logic        tx_ready;

    logic        busy, done, mem_re, tx_valid;
    logic [6:0]  mem_read_addr;
    logic [15:0] mem_qout, tx_data;

    logic        w_busy, w_done, w_re, w_valid;
    logic [3:0]  w_addr;
    logic [15:0] w_qout, w_data;

    logic [15:0] mem   [128];
    logic [15:0] mem16 [16];

    int n_cmp = 0;
    int n_bad = 0;

    operand_stream_tx #(
        .DATA_WIDTH (16),
        .MEM_HEIGHT (128),
        .LEN_WIDTH  (20)
    ) dut (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .start         (start),
        .base_addr     (base[6:0]),
        .length        (len),
        .busy          (busy),
        .done          (done),
        .mem_re        (mem_re),
        .mem_read_addr (mem_read_addr),
        .mem_qout      (mem_qout),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    operand_stream_tx #(
        .DATA_WIDTH (16),
        .MEM_HEIGHT (16),
        .LEN_WIDTH  (20)
    ) dut16 (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .start         (start16),
        .base_addr     (base[3:0]),
        .length        (len),
        .busy          (w_busy),
        .done          (w_done),
        .mem_re        (w_re),
        .mem_read_addr (w_addr),
        .mem_qout      (w_qout),
        .tx_data       (w_data),
        .tx_valid      (w_valid),
        .tx_ready      (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_qout <= mem[mem_read_addr];
        if (w_re)   w_qout   <= mem16[w_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        n_cmp++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s: got %0d want <= %0d", nm, act, lim);
        end
    endtask

    // stream model: word list, counts and expected busy/done
    logic [15:0] mq[$];
    bit          m_busy, m_done_due, nbusy, ndone;
    int          m_base, m_len, m_issued, m_popped;
    bit          prev_stall, pop_now;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        pop_now = tx_valid && tx_ready;
        if (!arst_n_in) begin
            m_busy = 0; m_done_due = 0; m_len = 0;
            m_issued = 0; m_popped = 0; prev_stall = 0;
            mq.delete();
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done_due);
            if (!m_busy) begin
                chk("idle_valid", tx_valid, 0);
                chk("idle_re", mem_re, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_data);
            end
            if (tx_valid) begin
                if (mq.size() == 0) chk("extra_word", tx_valid, 0);
                else                chk("data", tx_data, mq[0]);
            end
            if (mem_re) begin
                chk("rd_addr", mem_read_addr, (m_base + m_issued) % 128);
                chk_le("issued", m_issued + 1, m_len);
                m_issued++;
            end
            if (pop_now && mq.size() != 0) begin
                void'(mq.pop_front());
                m_popped++;
            end
            chk_le("outstanding", m_issued - m_popped, 2);
            nbusy = m_busy;
            ndone = 0;
            if (m_busy && pop_now && m_popped == m_len) begin
                nbusy = 0;
                ndone = 1;
            end
            if (!m_busy && !m_done_due && start) begin
                if (len == 0) begin
                    ndone = 1;
                end else begin
                    nbusy = 1;
                    m_base = int'(base[6:0]);
                    m_len = int'(len);
                    m_issued = 0;
                    m_popped = 0;
                    mq.delete();
                    for (int k = 0; k < m_len; k++)
                        mq.push_back(mem[(m_base + k) % 128]);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            m_busy     = nbusy;
            m_done_due = ndone;
        end
    end

    logic        tr_busy [32];
    logic        tr_re   [32];
    logic        tr_val  [32];
    logic        tr_done [32];
    logic [15:0] seq[$];
    int          n_done;

    task automatic launch(input int b, input int l);
        base  = 16'(b);
        len   = 20'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // cycle k of the trace is the k-th cycle after the accepting edge
    task automatic trace(input int n, input logic [15:0] rdy,
                         input int st_at, input int rst_at);
        seq.delete();
        n_done = 0;
        for (int k = 1; k <= n; k++) begin
            tx_ready  = (k <= 16) ? rdy[k-1] : 1'b1;
            arst_n_in = (k != rst_at);
            start     = (k == st_at);
            if (k == st_at) begin
                base = 16'd0;
                len  = 20'd4;
            end
            @(negedge clk);
            tr_busy[k] = busy;
            tr_re[k]   = mem_re;
            tr_val[k]  = tx_valid;
            tr_done[k] = done;
            if (tx_valid && tx_ready) seq.push_back(tx_data);
            if (done) n_done++;
            @(posedge clk); #1;
        end
        start     = 1'b0;
        arst_n_in = 1'b1;
    endtask

    logic [15:0] e_base [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [15:0] e_rst  [3] = '{16'hFFB1, 16'hFFB2, 16'hFFB3};
    logic [15:0] e_wrap [4] = '{16'h010E, 16'h010F, 16'h0100, 16'h0101};
    int          e_wadr [4] = '{14, 15, 0, 1};
    int          aseq[$];

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'(i - 99);
        for (int i = 0; i < 16; i++)  mem16[i] = 16'(256 + i);
        arst_n_in = 1'b0;
        start = 1'b0; start16 = 1'b0;
        base = '0; len = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_addr", mem_read_addr, 0);
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        launch(100, 4);
        trace(9, 16'hFFFF, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("basic_busy%0d", k), tr_busy[k], k <= 6);
            chk($sformatf("basic_re%0d", k), tr_re[k], k <= 4);
            chk($sformatf("basic_val%0d", k), tr_val[k], k >= 3 && k <= 6);
            chk($sformatf("basic_done%0d", k), tr_done[k], k == 7);
        end
        chk("basic_n", seq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_d%0d", i), seq[i], e_base[i]);

        launch(100, 4);
        trace(14, 16'hFFE9, 0, 0);
        chk("bp_n", seq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_d%0d", i), seq[i], e_base[i]);
        chk("bp_dones", n_done, 1);

        launch(5, 0);
        trace(4, 16'hFFFF, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("zero_done%0d", k), tr_done[k], k == 1);
            chk($sformatf("zero_busy%0d", k), tr_busy[k], 0);
            chk($sformatf("zero_re%0d", k), tr_re[k], 0);
            chk($sformatf("zero_val%0d", k), tr_val[k], 0);
        end

        launch(100, 4);
        trace(12, 16'hFFFF, 2, 0);
        chk("sib_n", seq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("sib_d%0d", i), seq[i], e_base[i]);
        chk("sib_dones", n_done, 1);

        launch(100, 4);
        trace(10, 16'hFFEF, 0, 5);
        chk("rst_mid_n", seq.size(), 2);
        chk("rst_mid_valid", tr_val[6], 0);
        chk("rst_mid_busy", tr_busy[6], 0);
        chk("rst_mid_done", tr_done[6], 0);
        chk("rst_mid_dones", n_done, 0);
        launch(20, 3);
        trace(8, 16'hFFFF, 0, 0);
        chk("restart_n", seq.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("restart_d%0d", i), seq[i], e_rst[i]);
        chk("restart_dones", n_done, 1);

        base = 16'd14; len = 20'd4; tx_ready = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        seq.delete(); aseq.delete(); n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (w_re) aseq.push_back(int'(w_addr));
            if (w_valid && tx_ready) seq.push_back(w_data);
            if (w_done) n_done++;
            @(posedge clk); #1;
        end
        chk("wrap_na", aseq.size(), 4);
        chk("wrap_nd", seq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_a%0d", i), aseq[i], e_wadr[i]);
            chk($sformatf("wrap_d%0d", i), seq[i], e_wrap[i]);
        end
        chk("wrap_dones", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
